// File: rtl/chunk_mem_ctrl.sv
// chunk_mem_ctrl: DEPTH-entry chunk store with whole-chunk access and a narrow host beat stream
// Ports:
//   clk, rst (sync, active-low)
//   cmd_valid/cmd_ready/cmd_op/cmd_addr : command handshake (00 host wr, 01 host rd, 10 chunk wr, 11 chunk rd)
//   host_in_*  : host write beat stream (beat 0 = chunk LSBs)
//   host_out_* : host read beat stream, host_out_last flags beat BEATS-1
//   chunk_in   : chunk write data, sampled at command accept
//   chunk_out/chunk_out_valid : chunk read data and one-cycle update pulse
//   busy       : !cmd_ready
//   op_count   : completed-operation counter, present only with CHUNK_MEM_CTRL_OPCNT_EN
module chunk_mem_ctrl #(
   parameter int CHUNK_BITS = 512,
   parameter int HOST_BITS  = 8,
   parameter int DEPTH      = 16,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [HOST_BITS-1:0]  host_in_data,
   input  logic                  host_in_valid,
   output logic                  host_in_ready,
   output logic [HOST_BITS-1:0]  host_out_data,
   output logic                  host_out_valid,
   input  logic                  host_out_ready,
   output logic                  host_out_last,
   input  logic [CHUNK_BITS-1:0] chunk_in,
   output logic [CHUNK_BITS-1:0] chunk_out,
   output logic                  chunk_out_valid,
   output logic                  busy
`ifdef CHUNK_MEM_CTRL_OPCNT_EN
   ,
   output logic [15:0]           op_count
`endif
);
   localparam int BEATS = CHUNK_BITS / HOST_BITS;
   localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, HWR, HRD, CRD} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [CHUNK_BITS-1:0] sreg_q, sreg_d;
   logic [CHUNK_BITS-1:0] cout_q, cout_d;
   logic [CHUNK_BITS-1:0] mem [DEPTH];
   logic                  we;
   logic [ADDR_W-1:0]     waddr;
   logic [CHUNK_BITS-1:0] wdata;
   logic                  last;

   assign last            = cnt_q == CW'(BEATS - 1);
   assign cmd_ready       = state_q == IDLE;
   assign busy            = !cmd_ready;
   assign host_in_ready   = state_q == HWR;
   assign host_out_valid  = state_q == HRD;
   assign host_out_last   = host_out_valid && last;
   assign host_out_data   = sreg_q[HOST_BITS-1:0];
   assign chunk_out       = cout_q;
   assign chunk_out_valid = state_q == CRD;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      sreg_d  = sreg_q;
      cout_d  = cout_q;
      we      = 1'b0;
      waddr   = addr_q;
      wdata   = chunk_in;
      unique case (state_q)
         IDLE: if (cmd_valid) begin
            addr_d = cmd_addr;
            cnt_d  = '0;
            unique case (cmd_op)
               2'b00: state_d = HWR;
               2'b01: begin
                  state_d = HRD;
                  sreg_d  = mem[cmd_addr];
               end
               2'b10: begin
                  we    = 1'b1;
                  waddr = cmd_addr;
               end
               default: begin
                  state_d = CRD;
                  cout_d  = mem[cmd_addr];
               end
            endcase
         end
         HWR: if (host_in_valid) begin
            sreg_d[int'(cnt_q)*HOST_BITS +: HOST_BITS] = host_in_data;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               // commit includes the beat landing on this same edge
               we      = 1'b1;
               wdata   = sreg_d;
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         HRD: if (host_out_ready) begin
            sreg_d = sreg_q >> HOST_BITS;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         sreg_q  <= '0;
         cout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         sreg_q  <= sreg_d;
         cout_q  <= cout_d;
      end
   end

   // storage survives reset; a reset edge blocks any pending write
   always_ff @(posedge clk) begin
      if (we && rst) mem[waddr] <= wdata;
   end

`ifdef CHUNK_MEM_CTRL_OPCNT_EN
   logic [15:0] op_q, op_d;
   logic        done;
   assign done = (state_q == IDLE && cmd_valid && cmd_op == 2'b10) || state_q == CRD ||
                 (state_q == HWR && host_in_valid && last) ||
                 (state_q == HRD && host_out_ready && last);
   assign op_d     = op_q + {15'd0, done};
   assign op_count = op_q;
   always_ff @(posedge clk) begin
      if (!rst) op_q <= '0;
      else      op_q <= op_d;
   end
`endif
endmodule

// File: tb/tb_chunk_mem_ctrl.sv
// tb_chunk_mem_ctrl: directed self-checking bench for chunk_mem_ctrl at default parameters
module tb_chunk_mem_ctrl;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b00;
   logic [3:0]   cmd_addr = 4'd0;
   logic [7:0]   host_in_data = 8'd0;
   logic         host_in_valid = 1'b0;
   logic         host_in_ready;
   logic [7:0]   host_out_data;
   logic         host_out_valid;
   logic         host_out_ready = 1'b0;
   logic         host_out_last;
   logic [511:0] chunk_in = '0;
   logic [511:0] chunk_out;
   logic         chunk_out_valid;
   logic         busy;
`ifdef CHUNK_MEM_CTRL_OPCNT_EN
   logic [15:0]  op_count;
`endif
   int errors = 0;
   int checks = 0;

   chunk_mem_ctrl dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .host_in_data(host_in_data), .host_in_valid(host_in_valid),
      .host_in_ready(host_in_ready), .host_out_data(host_out_data), .host_out_valid(host_out_valid),
      .host_out_ready(host_out_ready), .host_out_last(host_out_last), .chunk_in(chunk_in),
      .chunk_out(chunk_out), .chunk_out_valid(chunk_out_valid), .busy(busy)
`ifdef CHUNK_MEM_CTRL_OPCNT_EN
      , .op_count(op_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [3:0] a);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      while (!cmd_ready && n < 200) begin
         tick;
         n++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_accept_timeout op=%0d addr=%0d cmd_ready=%b required 1", op, a, cmd_ready);
      end
      tick;
      cmd_valid = 1'b0;
   endtask

   task automatic host_write(input logic [3:0] a, input int beats, input logic [7:0] base);
      do_cmd(2'b00, a);
      for (int k = 0; k < beats; k++) begin
         host_in_valid = 1'b1;
         host_in_data  = base + 8'(k);
         tick;
      end
      host_in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      tick;
      checks += 8;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (host_in_ready !== 1'b0) begin errors++; $display("FAIL rst_host_in_ready got=%b exp=0", host_in_ready); end
      if (host_out_valid !== 1'b0) begin errors++; $display("FAIL rst_host_out_valid got=%b exp=0", host_out_valid); end
      if (host_out_last !== 1'b0) begin errors++; $display("FAIL rst_host_out_last got=%b exp=0", host_out_last); end
      if (chunk_out_valid !== 1'b0) begin errors++; $display("FAIL rst_chunk_out_valid got=%b exp=0", chunk_out_valid); end
      if (chunk_out !== 512'd0) begin errors++; $display("FAIL rst_chunk_out got=%h exp=0", chunk_out); end
      if (host_out_data !== 8'd0) begin errors++; $display("FAIL rst_host_out_data got=%h exp=0", host_out_data); end
   endtask

   task automatic test_host_write;
      logic [511:0] exp;
      int gap;
      for (int k = 0; k < 64; k++) exp[k*8 +: 8] = 8'(k);
      do_cmd(2'b00, 4'd3);
      checks += 2;
      if (host_in_ready !== 1'b1) begin errors++; $display("FAIL hwr_ready got=%b exp=1", host_in_ready); end
      if (busy !== 1'b1) begin errors++; $display("FAIL hwr_busy got=%b exp=1", busy); end
      for (int k = 0; k < 64; k++) begin
         if (k == 10) begin
            gap = int'($urandom_range(1, 4));
            host_in_valid = 1'b0;
            for (int g = 0; g < gap; g++) tick;
            checks++;
            if (host_in_ready !== 1'b1) begin errors++; $display("FAIL hwr_gap_hold ready=%b exp=1", host_in_ready); end
         end
         host_in_valid = 1'b1;
         host_in_data  = 8'(k);
         tick;
      end
      host_in_valid = 1'b0;
      checks += 2;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL hwr_done_cmd_ready got=%b exp=1", cmd_ready); end
      if (host_in_ready !== 1'b0) begin errors++; $display("FAIL hwr_done_in_ready got=%b exp=0", host_in_ready); end
      do_cmd(2'b11, 4'd3);
      checks += 3;
      if (chunk_out_valid !== 1'b1) begin errors++; $display("FAIL crd_valid got=%b exp=1", chunk_out_valid); end
      if (chunk_out !== exp) begin errors++; $display("FAIL crd_data got=%h exp=%h", chunk_out, exp); end
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL crd_busy cmd_ready=%b exp=0", cmd_ready); end
      tick;
      checks += 3;
      if (chunk_out_valid !== 1'b0) begin errors++; $display("FAIL crd_pulse got=%b exp=0", chunk_out_valid); end
      if (chunk_out !== exp) begin errors++; $display("FAIL crd_hold got=%h exp=%h", chunk_out, exp); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL crd_idle cmd_ready=%b exp=1", cmd_ready); end
   endtask

   task automatic test_host_read_stall;
      logic [511:0] pat;
      for (int k = 0; k < 64; k++) pat[k*8 +: 8] = 8'hA5 ^ 8'(k);
      chunk_in = pat;
      do_cmd(2'b10, 4'd15);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cwr_stays_idle cmd_ready=%b exp=1", cmd_ready); end
      chunk_in = '0;
      do_cmd(2'b01, 4'd15);
      for (int k = 0; k < 64; k++) begin
         if (k == 20) begin
            host_out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick;
               checks += 2;
               if (host_out_valid !== 1'b1 || host_out_data !== pat[k*8 +: 8]) begin
                  errors++;
                  $display("FAIL hrd_stall_hold cyc=%0d valid=%b data=%h exp valid=1 data=%h", s, host_out_valid, host_out_data, pat[k*8 +: 8]);
               end
               if (host_out_last !== 1'b0) begin errors++; $display("FAIL hrd_stall_last got=%b exp=0", host_out_last); end
            end
         end
         host_out_ready = 1'b1;
         checks += 2;
         if (host_out_valid !== 1'b1 || host_out_data !== pat[k*8 +: 8]) begin
            errors++;
            $display("FAIL hrd_beat k=%0d valid=%b data=%h exp valid=1 data=%h", k, host_out_valid, host_out_data, pat[k*8 +: 8]);
         end
         if (host_out_last !== (k == 63)) begin
            errors++;
            $display("FAIL hrd_last k=%0d got=%b exp=%b", k, host_out_last, k == 63);
         end
         tick;
      end
      host_out_ready = 1'b0;
      checks += 2;
      if (host_out_valid !== 1'b0) begin errors++; $display("FAIL hrd_end_valid got=%b exp=0", host_out_valid); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL hrd_end_cmd_ready got=%b exp=1", cmd_ready); end
   endtask

   task automatic test_cmd_while_busy;
      logic [511:0] p1, p2;
      p1 = {16{32'h1234_5678}};
      p2 = {16{32'hCAFE_F00D}};
      chunk_in = p1;
      do_cmd(2'b10, 4'd7);
      do_cmd(2'b01, 4'd7);
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_addr  = 4'd7;
      chunk_in  = p2;
      host_out_ready = 1'b1;
      for (int k = 0; k < 64; k++) begin
         checks += 2;
         if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_cmd_ready k=%0d got=%b exp=0", k, cmd_ready); end
         if (host_out_data !== p1[k*8 +: 8]) begin
            errors++;
            $display("FAIL busy_stream k=%0d got=%h exp=%h", k, host_out_data, p1[k*8 +: 8]);
         end
         tick;
      end
      host_out_ready = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL busy_release cmd_ready=%b exp=1", cmd_ready); end
      tick;
      cmd_valid = 1'b0;
      chunk_in  = '0;
      do_cmd(2'b11, 4'd7);
      checks++;
      if (chunk_out !== p2) begin errors++; $display("FAIL busy_cwr_commit got=%h exp=%h", chunk_out, p2); end
   endtask

   task automatic test_reset_mid_hwr;
      chunk_in = {512{1'b1}};
      do_cmd(2'b10, 4'd5);
      chunk_in = '0;
      host_write(4'd5, 30, 8'h00);
      host_in_valid = 1'b1;
      host_in_data  = 8'h1E;
      rst = 1'b0;
      tick;
      rst = 1'b1;
      host_in_valid = 1'b0;
      tick;
      checks += 3;
      if (host_in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got=%b exp=0", host_in_ready); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_cmd_ready got=%b exp=1", cmd_ready); end
      if (chunk_out !== 512'd0) begin errors++; $display("FAIL abort_chunk_out_clr got=%h exp=0", chunk_out); end
      do_cmd(2'b11, 4'd5);
      checks++;
      if (chunk_out !== {512{1'b1}}) begin errors++; $display("FAIL abort_storage got=%h exp=all ff", chunk_out); end
   endtask

`ifdef CHUNK_MEM_CTRL_OPCNT_EN
   task automatic test_opcnt;
      host_write(4'd9, 12, 8'h40);
      rst = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      checks++;
      if (op_count !== 16'd0) begin errors++; $display("FAIL opcnt_reset got=%0d exp=0", op_count); end
      chunk_in = {16{32'h0BAD_F00D}};
      do_cmd(2'b10, 4'd1);
      do_cmd(2'b10, 4'd2);
      host_write(4'd4, 64, 8'h10);
      do_cmd(2'b01, 4'd4);
      host_out_ready = 1'b1;
      for (int k = 0; k < 64; k++) tick;
      host_out_ready = 1'b0;
      checks++;
      if (op_count !== 16'd4) begin errors++; $display("FAIL opcnt_total got=%0d exp=4", op_count); end
   endtask
`endif

   initial begin
      test_reset;
      test_host_write;
      test_host_read_stall;
      test_cmd_while_busy;
      test_reset_mid_hwr;
`ifdef CHUNK_MEM_CTRL_OPCNT_EN
      test_opcnt;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
